// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   state_t   : arbiter FSM states
//   GNT_INSTR : grant id for the instruction bus
//   GNT_DATA  : grant id for the data bus
package arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUSY_I,
      ST_BUSY_D,
      ST_DONE_I,
      ST_DONE_D
   } state_t;

   localparam logic GNT_INSTR = 1'b0;
   localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the CPU instruction bus, CPU data bus and unified memory port.
//   slave  : arbiter view (takes CPU requests and memory responses, drives acks/strobes)
//   master : environment view (CPU requesters and memory model)
// Signal names keep the i/o prefixes as seen from the arbiter.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  iIReq;
   logic [ADDR_W-1:0]     iIAddress;
   logic [DATA_W-1:0]     oIReadData;
   logic                  oIAck;

   logic                  iDReq;
   logic                  iDWrite;
   logic [DATA_W/8-1:0]   iDByteEnable;
   logic [ADDR_W-1:0]     iDAddress;
   logic [DATA_W-1:0]     iDWriteData;
   logic [DATA_W-1:0]     oDReadData;
   logic                  oDAck;

   logic                  oMemReadEnable;
   logic                  oMemWriteEnable;
   logic [DATA_W/8-1:0]   oMemByteEnable;
   logic [ADDR_W-1:0]     oMemAddress;
   logic [DATA_W-1:0]     oMemWriteData;
   logic [DATA_W-1:0]     iMemReadData;
   logic                  iMemReady;

   logic                  oBusy;

   modport slave (
      input  iIReq, iIAddress, iDReq, iDWrite, iDByteEnable, iDAddress, iDWriteData,
             iMemReadData, iMemReady,
      output oIReadData, oIAck, oDReadData, oDAck,
             oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
             oBusy
   );

   modport master (
      output iIReq, iIAddress, iDReq, iDWrite, iDByteEnable, iDAddress, iDWriteData,
             iMemReadData, iMemReady,
      input  oIReadData, oIAck, oDReadData, oDAck,
             oMemReadEnable, oMemWriteEnable, oMemByteEnable, oMemAddress, oMemWriteData,
             oBusy
   );

endinterface

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Combinational grant selection between instruction and data requests.
//   iIReq, iDReq : pending requests
//   last_grant   : side granted most recently (round-robin build only)
//   grant_valid  : at least one request pending
//   grant_id     : GNT_INSTR or GNT_DATA
// Macro ARB_ROUND_ROBIN_EN: defined -> a tie goes to the side not granted last;
// undefined -> a tie always goes to DATA.
module arb_grant_sel
   import arb_pkg::*;
(
   input  logic iIReq,
   input  logic iDReq,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic last_grant,
`endif
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = iIReq | iDReq;
      grant_id    = GNT_INSTR;
      if (iIReq && iDReq) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant_id = (last_grant == GNT_DATA) ? GNT_INSTR : GNT_DATA;
`else
         grant_id = GNT_DATA;
`endif
      end else if (iDReq) begin
         grant_id = GNT_DATA;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one memory port between the CPU instruction bus (read-only)
// and data bus (read/write). One access in flight at a time; each completed
// access returns a one-cycle ack with registered read data.
//   iCLK, iRST : clock, asynchronous active-high reset
//   bus        : mem_bus_arbiter_if.slave (CPU buses, memory port, oBusy)
// Macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see arb_grant_sel).
//
// state     | meaning
// ST_IDLE   | waiting for a request, grant taken here
// ST_BUSY_I | instruction read on the memory port, waiting for iMemReady
// ST_BUSY_D | data read/write on the memory port, waiting for iMemReady
// ST_DONE_I | oIAck pulse, requests ignored
// ST_DONE_D | oDAck pulse, requests ignored
module mem_bus_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              iCLK,
   input  logic              iRST,
   mem_bus_arbiter_if.slave  bus
);

   localparam int BE_W = DATA_W / 8;

   state_t              state, state_nxt;
   logic                grant_valid, grant_id, load;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, i_rdata_q, d_rdata_q;
   logic [BE_W-1:0]     be_q;
   logic                wr_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)      last_grant <= GNT_INSTR;
      else if (load) last_grant <= grant_id;
   end
`endif

   arb_grant_sel u_grant_sel (
      .iIReq       (bus.iIReq),
      .iDReq       (bus.iDReq),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant  (last_grant),
`endif
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_valid) begin
               load      = 1'b1;
               state_nxt = (grant_id == GNT_DATA) ? ST_BUSY_D : ST_BUSY_I;
            end
         end
         ST_BUSY_I: if (bus.iMemReady) state_nxt = ST_DONE_I;
         ST_BUSY_D: if (bus.iMemReady) state_nxt = ST_DONE_D;
         ST_DONE_I,
         ST_DONE_D: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Request fields are captured only at the grant edge; write data is left
   // untouched by an instruction grant so it keeps its last value.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         wr_q    <= 1'b0;
      end else if (load) begin
         if (grant_id == GNT_DATA) begin
            addr_q  <= bus.iDAddress;
            wdata_q <= bus.iDWriteData;
            be_q    <= bus.iDByteEnable;
            wr_q    <= bus.iDWrite;
         end else begin
            addr_q  <= bus.iIAddress;
            be_q    <= '1;
            wr_q    <= 1'b0;
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (bus.iMemReady) begin
         if (state == ST_BUSY_I)           i_rdata_q <= bus.iMemReadData;
         if (state == ST_BUSY_D && !wr_q)  d_rdata_q <= bus.iMemReadData;
      end
   end

   assign bus.oMemReadEnable  = (state == ST_BUSY_I) || (state == ST_BUSY_D && !wr_q);
   assign bus.oMemWriteEnable = (state == ST_BUSY_D) && wr_q;
   assign bus.oMemAddress     = addr_q;
   assign bus.oMemWriteData   = wdata_q;
   assign bus.oMemByteEnable  = be_q;
   assign bus.oIAck           = (state == ST_DONE_I);
   assign bus.oDAck           = (state == ST_DONE_D);
   assign bus.oIReadData      = i_rdata_q;
   assign bus.oDReadData      = d_rdata_q;
   assign bus.oBusy           = (state != ST_IDLE);

endmodule
